// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_pkg
// Description : Shared types and constants for the I2C register sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    localparam int SYNC_DEPTH = 2;
    localparam int ACK_EDGES  = 9;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        PTR_START = 4'd1,
        PTR_RUN   = 4'd2,
        RD_START  = 4'd3,
        RD_RUN    = 4'd4,
        WR_START  = 4'd5,
        WR_RUN    = 4'd6,
        RECOVER   = 4'd7,
        RESP      = 4'd8
    } state_t;

    // Byte queue: register pointer first, then write data MSB-first.
    function automatic logic [7:0] queue_byte(input logic [7:0]  reg_ptr,
                                              input logic [31:0] wdata,
                                              input logic [2:0]  idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = reg_ptr;
            3'd1:    b = wdata[31:24];
            3'd2:    b = wdata[23:16];
            3'd3:    b = wdata[15:8];
            default: b = wdata[7:0];
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : i2c_sync_edge
// Description : Multi-flop synchronizer with rise/fall pulses on the synced copy.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_sync_edge
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [SYNC_DEPTH-1:0] r_sync;
    logic                  r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_DEPTH-2:0], async_in};
            r_prev <= r_sync[SYNC_DEPTH-1];
        end
    end

    assign sync_out = r_sync[SYNC_DEPTH-1];
    assign rise     = sync_out & ~r_prev;
    assign fall     = ~sync_out & r_prev;

endmodule
`default_nettype wire

// File: rtl/i2c_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : i2c_reg_ctrl
// Description : Register read/write sequencer driving an i2c_master handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_reg_ctrl
    import i2c_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1048576,
    parameter int RST_PULSE   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_read,
    input  logic [6:0]  cmd_dev,
    input  logic [7:0]  cmd_reg,
    input  logic [1:0]  cmd_len,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    input  logic        m_busy,
    input  logic        m_newData,
    input  logic        m_dataReq,
    input  logic        m_scl,
    output logic        m_start,
    output logic        m_data_valid,
    output logic        m_read_nwrite,
    output logic [1:0]  m_byte_size,
    output logic [6:0]  m_addr,
    output logic [7:0]  m_data_i,
    input  logic [7:0]  m_data_o,
    output logic        master_rst
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + RST_PULSE + 1);

    state_t            r_state, w_next;
    logic              r_read;
    logic [6:0]        r_dev;
    logic [7:0]        r_reg;
    logic [1:0]        r_len;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic [2:0]        r_idx;
    logic [2:0]        r_rcnt;
    logic [3:0]        r_edges;
    logic              r_dv;
    logic [7:0]        r_data_i;
    logic [WD_W-1:0]   r_wdog;

    logic w_busy, w_busy_rise, w_busy_fall;
    logic w_nd, w_nd_rise, w_nd_fall;
    logic w_dreq, w_dreq_rise, w_dreq_fall;
    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_unused;

    i2c_sync_edge u_sync_busy (.clk(clk), .rst(rst), .async_in(m_busy),
                               .sync_out(w_busy), .rise(w_busy_rise), .fall(w_busy_fall));
    i2c_sync_edge u_sync_nd   (.clk(clk), .rst(rst), .async_in(m_newData),
                               .sync_out(w_nd), .rise(w_nd_rise), .fall(w_nd_fall));
    i2c_sync_edge u_sync_dreq (.clk(clk), .rst(rst), .async_in(m_dataReq),
                               .sync_out(w_dreq), .rise(w_dreq_rise), .fall(w_dreq_fall));
    i2c_sync_edge u_sync_scl  (.clk(clk), .rst(rst), .async_in(m_scl),
                               .sync_out(w_scl), .rise(w_scl_rise), .fall(w_scl_fall));

    assign w_unused = &{1'b0, w_busy_rise, w_nd, w_nd_rise, w_dreq_rise, w_dreq_fall,
                        w_scl, w_scl_rise, r_read};

    logic       w_timeout, w_feed_st, w_cap_st, w_wd_st;
    logic [2:0] w_qlen;

    assign w_timeout = (r_wdog == WD_W'(TIMEOUT_CYC - 1));
    assign w_feed_st = (r_state == PTR_START) || (r_state == PTR_RUN) ||
                       (r_state == WR_START)  || (r_state == WR_RUN);
    assign w_cap_st  = (r_state == RD_START)  || (r_state == RD_RUN);
    // RECOVER reuses the watchdog as its pulse timer.
    assign w_wd_st   = w_feed_st || w_cap_st || (r_state == RECOVER);
    assign w_qlen    = ((r_state == PTR_START) || (r_state == PTR_RUN)) ?
                       3'd1 : ({1'b0, r_len} + 3'd2);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        cmd_ready     = 1'b0;
        rsp_valid     = 1'b0;
        master_rst    = 1'b0;
        m_start       = 1'b0;
        m_read_nwrite = 1'b0;
        m_byte_size   = 2'd0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    w_next = cmd_read ? PTR_START : ((cmd_len == 2'd3) ? RESP : WR_START);
            end
            PTR_START: begin
                m_start = 1'b1;
                if (w_timeout)   w_next = RECOVER;
                else if (w_busy) w_next = PTR_RUN;
            end
            PTR_RUN: begin
                if (w_timeout)        w_next = RECOVER;
                else if (w_busy_fall) w_next = RD_START;
            end
            RD_START: begin
                m_start       = 1'b1;
                m_read_nwrite = 1'b1;
                m_byte_size   = r_len;
                if (w_timeout)   w_next = RECOVER;
                else if (w_busy) w_next = RD_RUN;
            end
            RD_RUN: begin
                m_read_nwrite = 1'b1;
                m_byte_size   = r_len;
                if (w_timeout)        w_next = RECOVER;
                else if (w_busy_fall) w_next = RESP;
            end
            WR_START: begin
                m_start     = 1'b1;
                m_byte_size = r_len + 2'd1;
                if (w_timeout)   w_next = RECOVER;
                else if (w_busy) w_next = WR_RUN;
            end
            WR_RUN: begin
                m_byte_size = r_len + 2'd1;
                if (w_timeout)        w_next = RECOVER;
                else if (w_busy_fall) w_next = RESP;
            end
            RECOVER: begin
                master_rst = 1'b1;
                if (r_wdog == WD_W'(RST_PULSE - 1)) w_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_read   <= 1'b0;
            r_dev    <= '0;
            r_reg    <= '0;
            r_len    <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_idx    <= '0;
            r_rcnt   <= '0;
            r_edges  <= '0;
            r_dv     <= 1'b0;
            r_data_i <= '0;
            r_wdog   <= '0;
        end else begin
            if (r_state != w_next) r_wdog <= '0;
            else if (w_wd_st)      r_wdog <= r_wdog + 1'b1;

            if (r_state == IDLE && cmd_valid) begin
                r_read  <= cmd_read;
                r_dev   <= cmd_dev;
                r_reg   <= cmd_reg;
                r_len   <= cmd_len;
                r_wdata <= cmd_wdata;
                r_err   <= !cmd_read && (cmd_len == 2'd3);
                r_idx   <= '0;
                r_rcnt  <= '0;
                if (cmd_read) r_rdata <= '0;
            end

            if (r_state == RECOVER) r_err <= 1'b1;

            // Each byte is held through 8 data bits plus the ACK clock.
            if (w_feed_st) begin
                if (r_dv) begin
                    if (w_scl_fall) begin
                        if (r_edges == 4'(ACK_EDGES - 1)) begin
                            r_dv    <= 1'b0;
                            r_idx   <= r_idx + 3'd1;
                            r_edges <= '0;
                        end else begin
                            r_edges <= r_edges + 4'd1;
                        end
                    end
                end else if (w_dreq && (r_idx < w_qlen)) begin
                    r_data_i <= queue_byte(r_reg, r_wdata, r_idx);
                    r_dv     <= 1'b1;
                    r_edges  <= '0;
                end
            end else begin
                r_dv <= 1'b0;
            end

            if (w_cap_st && w_nd_fall && (r_rcnt <= {1'b0, r_len})) begin
                r_rdata <= {r_rdata[23:0], m_data_o};
                r_rcnt  <= r_rcnt + 3'd1;
            end
        end
    end

    assign rsp_err      = rsp_valid & r_err;
    assign rsp_rdata    = r_rdata;
    assign m_addr       = r_dev;
    assign m_data_i     = r_data_i;
    assign m_data_valid = r_dv;

endmodule
`default_nettype wire
